// File: rtl/interrupter_burst.sv
// DRSSTC interrupter: gates the resonant feedback square wave into the inverted gate-driver
// pair during a programmable window, with burst modulation and over-current lockout.
module interrupter_burst #(
  parameter int unsigned PAR_W     = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ADDR_BASE = 4,
  parameter int unsigned K1        = 20,
  parameter int unsigned K2        = 15,
  parameter int unsigned K3        = 9,
  parameter int unsigned SKIP_W    = 4,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen,
  input  logic              ocd,
  input  logic [PAR_W-1:0]  data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic              out_p,
  output logic              out_n,
  output logic              active,
  output logic              fault,
  output logic [FCNT_W-1:0] fault_cnt
);

  // counter holds 2^K1 + (max FREQ << K2) - 1; window compare is done wide enough for PW << K3
  localparam int unsigned CNT_W  = ((K1 > PAR_W + K2) ? K1 : PAR_W + K2) + 1;
  localparam int unsigned WIN_W  = (CNT_W > PAR_W + K3) ? CNT_W : PAR_W + K3;
  localparam int unsigned CTRL_W = SKIP_W + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, period_m1;
  logic [PAR_W-1:0]  freq, freq_nxt, pw, pw_nxt, bon, bon_nxt, boff, boff_nxt;
  logic [PAR_W-1:0]  bcnt, bcnt_nxt;
  logic [CTRL_W-1:0] ctrl, ctrl_nxt;
  logic [SKIP_W-1:0] skip, skip_nxt, skip_cfg;
  logic [FCNT_W-1:0] fault_cnt_nxt;
  logic              burst_on, burst_on_nxt, blk, blk_nxt;
  logic              gen_d, ocd_m, ocd_s;
  logic              out_p_nxt, out_n_nxt, active_nxt;
  logic              gen_edge, gen_rise, ena, burst_en, reload;

  assign ena       = ctrl[0];
  assign burst_en  = ctrl[1];
  assign skip_cfg  = ctrl[CTRL_W-1:2];
  assign gen_edge  = gen ^ gen_d;
  assign gen_rise  = gen & ~gen_d;
  assign reload    = (cnt == '0);
  assign period_m1 = (CNT_W'(1) << K1) + (CNT_W'(freq) << K2) - CNT_W'(1);

  // next-state for counter, burst sequencer, FSM, register file and outputs
  always_comb begin
    freq_nxt      = freq;
    pw_nxt        = pw;
    bon_nxt       = bon;
    boff_nxt      = boff;
    ctrl_nxt      = ctrl;
    cnt_nxt       = reload ? period_m1 : cnt - CNT_W'(1);
    burst_on_nxt  = burst_on;
    bcnt_nxt      = bcnt;
    state_nxt     = state;
    skip_nxt      = skip;
    blk_nxt       = blk;
    fault_cnt_nxt = fault_cnt;

    if (reload) begin
      if (!burst_en) begin
        burst_on_nxt = 1'b1;
        bcnt_nxt     = '0;
      end else if (bcnt == (burst_on ? bon : boff)) begin
        burst_on_nxt = ~burst_on;
        bcnt_nxt     = '0;
      end else begin
        bcnt_nxt = bcnt + PAR_W'(1);
      end
    end

    // blk only moves on a gen edge so a half-cycle is never truncated
    case (state)
      ST_IDLE: begin
        if (gen_edge) blk_nxt = 1'b1;
        if (ena) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (gen_rise) blk_nxt = ocd_s | ~active;
        if (ocd_s) begin
          state_nxt = ST_FAULT;
          skip_nxt  = skip_cfg;
          if (fault_cnt != {FCNT_W{1'b1}}) fault_cnt_nxt = fault_cnt + FCNT_W'(1);
        end else if (!ena) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (gen_edge) blk_nxt = 1'b1;
        if (gen_rise && skip != '0) skip_nxt = skip - SKIP_W'(1);
        if (!ena) state_nxt = ST_IDLE;
        else if (skip == '0 && !ocd_s) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (en) begin
      if (addr == ADDR_W'(ADDR_BASE))     freq_nxt = data;
      if (addr == ADDR_W'(ADDR_BASE + 1)) pw_nxt   = data;
      if (addr == ADDR_W'(ADDR_BASE + 2)) bon_nxt  = data;
      if (addr == ADDR_W'(ADDR_BASE + 3)) boff_nxt = data;
      if (addr == ADDR_W'(ADDR_BASE + 4)) ctrl_nxt = data[CTRL_W-1:0];
    end

    active_nxt = (WIN_W'(cnt_nxt) < (WIN_W'(pw_nxt) << K3)) && burst_on_nxt &&
                 ctrl_nxt[0] && (state_nxt == ST_RUN);
    out_p_nxt  = gen & ~blk_nxt;
    out_n_nxt  = ~gen & ~blk_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      freq      <= '0;
      pw        <= '0;
      bon       <= '0;
      boff      <= '0;
      ctrl      <= '0;
      bcnt      <= '0;
      burst_on  <= 1'b1;
      skip      <= '0;
      blk       <= 1'b1;
      gen_d     <= 1'b0;
      ocd_m     <= 1'b0;
      ocd_s     <= 1'b0;
      fault_cnt <= '0;
      out_p     <= 1'b0;
      out_n     <= 1'b0;
      active    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      freq      <= freq_nxt;
      pw        <= pw_nxt;
      bon       <= bon_nxt;
      boff      <= boff_nxt;
      ctrl      <= ctrl_nxt;
      bcnt      <= bcnt_nxt;
      burst_on  <= burst_on_nxt;
      skip      <= skip_nxt;
      blk       <= blk_nxt;
      gen_d     <= gen;
      ocd_m     <= ocd;
      ocd_s     <= ocd_m;
      fault_cnt <= fault_cnt_nxt;
      out_p     <= out_p_nxt;
      out_n     <= out_n_nxt;
      active    <= active_nxt;
      fault     <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_interrupter_burst.sv
// Bench for interrupter_burst: a reference model predicts every cycle's outputs into a
// scoreboard, plus directed checks on period length, burst pattern and fault handling.
module tb_interrupter_burst;

  localparam int unsigned PAR_W  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ABASE  = 4;
  localparam int unsigned FCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst, gen, ocd, en;
  logic [PAR_W-1:0]  data;
  logic [ADDR_W-1:0] addr;
  logic              out_p, out_n, active, fault;
  logic [FCNT_W-1:0] fault_cnt;

  interrupter_burst #(.K1(6), .K2(2), .K3(2)) dut (
    .clk(clk), .rst(rst), .gen(gen), .ocd(ocd), .data(data), .addr(addr), .en(en),
    .out_p(out_p), .out_n(out_n), .active(active), .fault(fault), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gph     = 0;
  logic [31:0] sb_q[$];

  // reference model state (time-based period tracking)
  int m_t, m_ps, m_len, m_freq, m_pw, m_bon, m_boff, m_ctrl;
  int m_bph, m_bcnt, m_st, m_skip, m_blk, m_gd, m_s1, m_s2, m_fcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit g, input bit o, input bit e,
                            input int a, input int d);
    int cnt_o, cnt_c, sk_o, op, on, ac, fl;
    bit act_o, rise, edg, ena_o;
    if (r) begin
      m_t = 0; m_ps = 0; m_len = 1;
      m_freq = 0; m_pw = 0; m_bon = 0; m_boff = 0; m_ctrl = 0;
      m_bph = 1; m_bcnt = 0; m_st = 0; m_skip = 0; m_blk = 1;
      m_gd = 0; m_s1 = 0; m_s2 = 0; m_fcnt = 0;
    end else begin
      cnt_o = m_len - 1 - (m_t - m_ps);
      ena_o = (m_ctrl & 1) != 0;
      act_o = (cnt_o < m_pw * 4) && (m_bph != 0) && ena_o && (m_st == 1);
      rise  = g && (m_gd == 0);
      edg   = (int'(g) != m_gd);
      sk_o  = m_skip;
      m_t++;
      if (m_t == m_ps + m_len) begin
        m_ps  = m_t;
        m_len = 64 + 4 * m_freq;
        if ((m_ctrl & 2) == 0) begin
          m_bph = 1; m_bcnt = 0;
        end else if (m_bcnt == ((m_bph != 0) ? m_bon : m_boff)) begin
          m_bph = (m_bph != 0) ? 0 : 1; m_bcnt = 0;
        end else begin
          m_bcnt++;
        end
      end
      case (m_st)
        0: begin
          if (edg) m_blk = 1;
          if (ena_o) m_st = 1;
        end
        1: begin
          if (rise) m_blk = (m_s2 != 0 || !act_o) ? 1 : 0;
          if (m_s2 != 0) begin
            m_st = 2;
            m_skip = (m_ctrl >> 2) & 15;
            if (m_fcnt < 255) m_fcnt++;
          end else if (!ena_o) begin
            m_st = 0;
          end
        end
        default: begin
          if (edg) m_blk = 1;
          if (rise && sk_o != 0) m_skip = sk_o - 1;
          if (!ena_o) m_st = 0;
          else if (sk_o == 0 && m_s2 == 0) m_st = 1;
        end
      endcase
      m_s2 = m_s1; m_s1 = int'(o); m_gd = int'(g);
      if (e) begin
        case (a)
          4: m_freq = d;
          5: m_pw   = d;
          6: m_bon  = d;
          7: m_boff = d;
          8: m_ctrl = d & 63;
          default: ;
        endcase
      end
    end
    cnt_c = m_len - 1 - (m_t - m_ps);
    ac = ((cnt_c < m_pw * 4) && (m_bph != 0) && ((m_ctrl & 1) != 0) && (m_st == 1)) ? 1 : 0;
    op = (m_gd != 0 && m_blk == 0) ? 1 : 0;
    on = (m_gd == 0 && m_blk == 0) ? 1 : 0;
    fl = (m_st == 2) ? 1 : 0;
    sb_q.push_back(32'((op << 11) | (on << 10) | (ac << 9) | (fl << 8) | m_fcnt));
  endtask

  // drive one cycle at the falling edge, predict, then compare after the rising edge
  task automatic tick(input bit r, input bit o, input bit e, input int a, input int d);
    logic [31:0] exp_v, obs_v;
    bit g;
    g = ((gph / 4) % 2) == 1;
    gph++;
    rst = r; ocd = o; en = e; gen = g;
    addr = ADDR_W'(a); data = PAR_W'(d);
    model_step(r, g, o, e, a, d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs_v = {20'd0, out_p, out_n, active, fault, fault_cnt};
    exp_v = sb_q.pop_front();
    check($sformatf("cyc%0d", cyc), obs_v, exp_v);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int off, input int d);
    tick(0, 0, 1, ABASE + off, d);
  endtask

  task automatic wait_active(input bit level, input int budget, output int at, output bit ok);
    bit p;
    ok = 0; at = 0;
    for (int i = 0; i < budget; i++) begin
      p = active;
      tick(0, 0, 0, 0, 0);
      if (p != level && active == level) begin
        at = cyc; ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, t2, nact, rises;
    bit ok, gnext;

    // reset with gen toggling
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_n", 32'(out_n), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fcnt", 32'(fault_cnt), 32'd0);
    check("rst_active", 32'(active), 32'd0);

    // basic window, 64-cycle period
    wr(0, 0); wr(1, 4); wr(4, 1);
    idle(130);
    wait_active(1, 100, t0, ok); check("rise0_to", 32'(ok), 32'd1);
    wait_active(1, 100, t1, ok); check("rise1_to", 32'(ok), 32'd1);
    check("period64", 32'(t1 - t0), 32'd64);
    nact = 0;
    repeat (64) begin tick(0, 0, 0, 0, 0); nact += int'(active); end
    check("win16", 32'(nact), 32'd16);

    // burst 2 on / 1 off
    wr(2, 1); wr(3, 0); wr(4, 3);
    idle(250);
    nact = 0;
    repeat (192) begin tick(0, 0, 0, 0, 0); nact += int'(active); end
    check("burst_win", 32'(nact), 32'd32);

    // single fault with SKIP=3
    wr(4, 13);
    idle(70);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("fault_early", 32'(fault), 32'd0);
    tick(0, 0, 0, 0, 0);
    check("fault_lat", 32'(fault), 32'd1);
    rises = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      gnext = ((gph / 4) % 2) == 1;
      if (fault && gnext && !gen) rises++;
      tick(0, 0, 0, 0, 0);
      if (!fault) begin ok = 1; break; end
    end
    check("skip_to", 32'(ok), 32'd1);
    check("skip_rises", 32'(rises), 32'd3);
    check("fcnt1", 32'(fault_cnt), 32'd1);

    // fault counter saturation
    wr(4, 1);
    repeat (254) begin tick(0, 1, 0, 0, 0); idle(4); end
    check("fcnt255", 32'(fault_cnt), 32'd255);
    tick(0, 1, 0, 0, 0); idle(4);
    check("fcnt_sat", 32'(fault_cnt), 32'd255);

    // ENA cleared while in FAULT
    wr(4, 13); idle(2);
    tick(0, 1, 0, 0, 0); idle(2);
    check("flt_pre", 32'(fault), 32'd1);
    wr(4, 0);
    check("flt_hold", 32'(fault), 32'd1);
    tick(0, 0, 0, 0, 0);
    check("ena_idle", 32'(fault), 32'd0);

    // FREQ change mid-period applies from the next reload
    wr(4, 1);
    wait_active(0, 200, t0, ok); check("fall0_to", 32'(ok), 32'd1);
    idle(20);
    wr(0, 4);
    wait_active(0, 200, t1, ok); check("fall1_to", 32'(ok), 32'd1);
    wait_active(0, 200, t2, ok); check("fall2_to", 32'(ok), 32'd1);
    check("period_cur", 32'(t1 - t0), 32'd64);
    check("period_new", 32'(t2 - t1), 32'd80);

    // reset during burst OFF
    wr(0, 0); wr(2, 0); wr(3, 2); wr(4, 3);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick(0, 0, 0, 0, 0);
      if (m_bph == 0) begin ok = 1; break; end
    end
    check("boff_to", 32'(ok), 32'd1);
    idle(5);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst2_out_p", 32'(out_p), 32'd0);
    check("rst2_out_n", 32'(out_n), 32'd0);
    check("rst2_active", 32'(active), 32'd0);
    check("rst2_fault", 32'(fault), 32'd0);
    check("rst2_fcnt", 32'(fault_cnt), 32'd0);
    wr(1, 4); wr(2, 0); wr(3, 2); wr(4, 3);
    wait_active(1, 150, t0, ok);
    check("on_after_rst", 32'(ok), 32'd1);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
